match_ctrl: RTL and testbench

MATCH_CTRL -- requirements
Module: match_ctrl

---
 rtl/match_pkg.sv | 33 +++
 rtl/edge_rise.sv | 33 +++
 rtl/match_ctrl.sv | 158 +++++++++++++++
 tb/tb_match_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
// Shared definitions for the match controller: state encoding, default match
// length and pause length, player codes and a saturating score helper.
// -----------------------------------------------------------------------------
package match_pkg;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_PAUSE     = 2'd2,
    ST_MATCH_END = 2'd3
  } state_e;

  localparam int WIN_SCORE_DEF    = 15;
  localparam int PAUSE_FRAMES_DEF = 90;

  localparam logic [1:0] PLAYER_NONE = 2'd0;
  localparam logic [1:0] PLAYER_1    = 2'd1;
  localparam logic [1:0] PLAYER_2    = 2'd2;

  // Increment a score but never pass the cap, so a score can never wrap.
  function automatic logic [3:0] score_inc(input logic [3:0] score,
                                           input logic [3:0] cap);
    if (score >= cap) begin
      score_inc = cap;
    end else begin
      score_inc = score + 4'd1;
    end
  endfunction

endpackage

// File: rtl/edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
// Rising-edge detector: remembers the previous input value in a register and
// flags a rise when the input is high and the remembered value is low.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (previous value forced low)
//   d_i    - level input
//   rise_o - high for the clock in which d_i is high and was low last clock
// -----------------------------------------------------------------------------
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // Previous-value register, updated every clock regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  // Clearing prev_q on reset means a level already high after reset
  // produces exactly one rise on the first clock.
  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/match_ctrl.sv
// -----------------------------------------------------------------------------
// match_ctrl
// Match sequencer for a two-player game: starts a match, counts points from
// the physics stage, freezes physics for a fixed number of frames after each
// point and declares the match winner.
// Ports:
//   clk, rst_n    - clock and asynchronous active-low reset
//   frame_tick    - one-clock frame strobe
//   start_btn     - debounced start button level
//   game_over     - point-ended level from the physics stage
//   winner        - point winner (1 = P1, 2 = P2, others ignored)
//   phys_en       - frame strobe gated to PLAY, drives the physics enable
//   p1_score      - P1 points
//   p2_score      - P2 points
//   state         - IDLE=0, PLAY=1, PAUSE=2, MATCH_END=3
//   match_winner  - winning player, valid in MATCH_END
//   last_point    - winner of the most recent scored point
// -----------------------------------------------------------------------------
module match_ctrl
  import match_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic       phys_en,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic [1:0] match_winner,
  output logic [1:0] last_point
);

  localparam logic [3:0] WIN_Q   = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_Q = 8'(PAUSE_FRAMES);

  state_e     state_q;
  logic [3:0] p1_q;
  logic [3:0] p2_q;
  logic [1:0] match_winner_q;
  logic [1:0] last_point_q;
  logic [7:0] pause_cnt_q;

  logic       go_rise_s;
  logic       start_rise_s;
  logic       point_ev_s;
  logic [3:0] p1_inc_s;
  logic [3:0] p2_inc_s;

  edge_rise u_go_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (game_over),
    .rise_o (go_rise_s)
  );

  edge_rise u_start_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (start_btn),
    .rise_o (start_rise_s)
  );

  // Edges outside PLAY are dropped; the detector itself keeps tracking, so a
  // level held through PAUSE does not look like a new edge later.
  assign point_ev_s = go_rise_s & (state_q == ST_PLAY);
  assign p1_inc_s   = score_inc(p1_q, WIN_Q);
  assign p2_inc_s   = score_inc(p2_q, WIN_Q);

  assign phys_en      = frame_tick & (state_q == ST_PLAY);
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign state        = state_q;
  assign match_winner = match_winner_q;
  assign last_point   = last_point_q;

  // Match FSM: state, scores, winner bookkeeping and pause counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      p1_q           <= 4'd0;
      p2_q           <= 4'd0;
      match_winner_q <= PLAYER_NONE;
      last_point_q   <= PLAYER_NONE;
      pause_cnt_q    <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise_s) begin
            state_q        <= ST_PLAY;
            p1_q           <= 4'd0;
            p2_q           <= 4'd0;
            match_winner_q <= PLAYER_NONE;
            last_point_q   <= PLAYER_NONE;
          end
        end

        ST_PLAY: begin
          // winner is sampled in the same clock the edge is seen; codes
          // other than 1 and 2 are ignored entirely.
          if (point_ev_s && (winner == PLAYER_1)) begin
            p1_q         <= p1_inc_s;
            last_point_q <= PLAYER_1;
            if (p1_inc_s == WIN_Q) begin
              state_q        <= ST_MATCH_END;
              match_winner_q <= PLAYER_1;
            end else begin
              state_q     <= ST_PAUSE;
              pause_cnt_q <= PAUSE_Q;
            end
          end else if (point_ev_s && (winner == PLAYER_2)) begin
            p2_q         <= p2_inc_s;
            last_point_q <= PLAYER_2;
            if (p2_inc_s == WIN_Q) begin
              state_q        <= ST_MATCH_END;
              match_winner_q <= PLAYER_2;
            end else begin
              state_q     <= ST_PAUSE;
              pause_cnt_q <= PAUSE_Q;
            end
          end
        end

        ST_PAUSE: begin
          // The tick that finds the counter at 1 is the last suppressed one.
          if (frame_tick) begin
            pause_cnt_q <= pause_cnt_q - 8'd1;
            if (pause_cnt_q <= 8'd1) begin
              state_q     <= ST_PLAY;
              pause_cnt_q <= 8'd0;
            end
          end
        end

        ST_MATCH_END: begin
          if (start_rise_s) begin
            state_q        <= ST_PAUSE;
            p1_q           <= 4'd0;
            p2_q           <= 4'd0;
            match_winner_q <= PLAYER_NONE;
            last_point_q   <= PLAYER_NONE;
            pause_cnt_q    <= PAUSE_Q;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_match_ctrl
// Directed bench for match_ctrl (WIN_SCORE = 3, PAUSE_FRAMES = 90). Expected
// output snapshots are queued when stimulus is applied and compared once the
// DUT has taken the clock edge.
// -----------------------------------------------------------------------------
module tb_match_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       start_btn;
  logic       game_over;
  logic [1:0] winner;
  logic       phys_en;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] state;
  logic [1:0] match_winner;
  logic [1:0] last_point;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] lp;
    logic [1:0] mw;
  } exp_t;

  exp_t exp_q[$];

  match_ctrl #(.WIN_SCORE(3), .PAUSE_FRAMES(90)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .game_over    (game_over),
    .winner       (winner),
    .phys_en      (phys_en),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .state        (state),
    .match_winner (match_winner),
    .last_point   (last_point)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [1:0] st, input logic [3:0] p1,
                          input logic [3:0] p2, input logic [1:0] lp, input logic [1:0] mw);
    exp_t e;
    e.tag = tag; e.st = st; e.p1 = p1; e.p2 = p2; e.lp = lp; e.mw = mw;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".state"}, 32'(state), 32'(e.st));
      chk({e.tag, ".p1"}, 32'(p1_score), 32'(e.p1));
      chk({e.tag, ".p2"}, 32'(p2_score), 32'(e.p2));
      chk({e.tag, ".last_point"}, 32'(last_point), 32'(e.lp));
      chk({e.tag, ".match_winner"}, 32'(match_winner), 32'(e.mw));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply n frame ticks, one per clock, counting phys_en pulses mid-cycle.
  task automatic run_ticks(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      #1;
      if (phys_en === 1'b1) pulses++;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic start_pulse();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic point_pulse(input logic [1:0] w);
    game_over = 1'b1;
    winner    = w;
    step();
    game_over = 1'b0;
    winner    = 2'd0;
    step();
  endtask

  initial begin
    int pulses;
    int trans;
    logic [1:0] prev_st;

    rst_n      = 1'b0;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    game_over  = 1'b0;
    winner     = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 2'd0, 4'd0, 4'd0, 2'd0, 2'd0);
    pop_check();
    chk("reset.cnt", 32'(dut.pause_cnt_q), 32'd0);
    rst_n = 1'b1;
    step();

    // Start, then five ticks in PLAY
    push_exp("start", 2'd1, 4'd0, 4'd0, 2'd0, 2'd0);
    start_pulse();
    pop_check();
    run_ticks(5, pulses);
    chk("play.pulses", 32'(pulses), 32'd5);

    // P2 point with game_over held high for 200 clocks
    game_over = 1'b1;
    winner    = 2'd2;
    push_exp("p2_point", 2'd2, 4'd0, 4'd1, 2'd2, 2'd0);
    step();
    pop_check();
    chk("pause.cnt_load", 32'(dut.pause_cnt_q), 32'd90);
    run_ticks(90, pulses);
    chk("pause.pulses", 32'(pulses), 32'd0);
    chk("pause.resume_state", 32'(state), 32'd1);
    repeat (109) step();
    push_exp("held_go", 2'd1, 4'd0, 4'd1, 2'd2, 2'd0);
    pop_check();
    run_ticks(1, pulses);
    chk("tick91.pulse", 32'(pulses), 32'd1);
    game_over = 1'b0;
    winner    = 2'd0;
    step();

    // Point edge with winner 0 is ignored
    push_exp("winner0", 2'd1, 4'd0, 4'd1, 2'd2, 2'd0);
    point_pulse(2'd0);
    pop_check();

    // Frame tick coinciding with a P1 point edge
    frame_tick = 1'b1;
    game_over  = 1'b1;
    winner     = 2'd1;
    #1;
    chk("same_clk.phys_en", 32'(phys_en), 32'd1);
    push_exp("same_clk", 2'd2, 4'd1, 4'd1, 2'd1, 2'd0);
    step();
    frame_tick = 1'b0;
    game_over  = 1'b0;
    winner     = 2'd0;
    pop_check();
    run_ticks(90, pulses);
    chk("pause2.pulses", 32'(pulses), 32'd0);

    // P1 reaches WIN_SCORE = 3
    push_exp("p1_2", 2'd2, 4'd2, 4'd1, 2'd1, 2'd0);
    point_pulse(2'd1);
    pop_check();
    run_ticks(90, pulses);
    push_exp("p1_win", 2'd3, 4'd3, 4'd1, 2'd1, 2'd1);
    point_pulse(2'd1);
    pop_check();

    // MATCH_END holds against edges and ticks
    point_pulse(2'd2);
    run_ticks(5, pulses);
    chk("end.pulses", 32'(pulses), 32'd0);
    push_exp("end_hold", 2'd3, 4'd3, 4'd1, 2'd1, 2'd1);
    pop_check();

    // Restart from MATCH_END goes through PAUSE
    push_exp("restart", 2'd2, 4'd0, 4'd0, 2'd0, 2'd0);
    start_pulse();
    pop_check();
    chk("restart.cnt", 32'(dut.pause_cnt_q), 32'd90);
    run_ticks(89, pulses);
    chk("restart.pulses", 32'(pulses), 32'd0);
    chk("restart.still_pause", 32'(state), 32'd2);
    run_ticks(1, pulses);
    chk("restart.play", 32'(state), 32'd1);

    // Start in PLAY is ignored
    start_pulse();
    chk("start_in_play", 32'(state), 32'd1);

    // Reset mid-PAUSE at counter 40
    push_exp("p2_again", 2'd2, 4'd0, 4'd1, 2'd2, 2'd0);
    point_pulse(2'd2);
    pop_check();
    run_ticks(50, pulses);
    chk("mid_pause.cnt", 32'(dut.pause_cnt_q), 32'd40);
    frame_tick = 1'b1;
    rst_n      = 1'b0;
    #1;
    chk("rst.phys_en", 32'(phys_en), 32'd0);
    chk("rst.cnt", 32'(dut.pause_cnt_q), 32'd0);
    push_exp("rst_mid", 2'd0, 4'd0, 4'd0, 2'd0, 2'd0);
    pop_check();
    frame_tick = 1'b0;

    // start_btn held through reset release and for 1000 clocks
    start_btn = 1'b1;
    step();
    rst_n = 1'b1;
    prev_st = state;
    trans = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (state !== prev_st) trans++;
      prev_st = state;
    end
    start_btn = 1'b0;
    chk("held_start.transitions", 32'(trans), 32'd1);
    push_exp("held_start", 2'd1, 4'd0, 4'd0, 2'd0, 2'd0);
    pop_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
